// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-unit result FIFOs drained one entry per cycle
// onto the CDB in round-robin order, with backpressure and flush.
module cdb_arbiter #(
  parameter int NUM_FU      = 4,
  parameter int ROB_TAG_LEN = 5,
  parameter int XLEN        = 32,
  parameter int QDEPTH      = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [NUM_FU-1:0]             fu_valid,
  input  logic [NUM_FU*ROB_TAG_LEN-1:0] fu_tag,
  input  logic [NUM_FU*XLEN-1:0]        fu_value,
  output logic [NUM_FU-1:0]             fu_stall,
  output logic                          cdb_valid,
  output logic [ROB_TAG_LEN-1:0]        cdb_tag,
  output logic [XLEN-1:0]               cdb_value,
  output logic [$clog2(NUM_FU)-1:0]     cdb_src
);

  localparam int SRC_W = $clog2(NUM_FU);
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  logic [ROB_TAG_LEN-1:0] tag_mem [NUM_FU][QDEPTH];
  logic [XLEN-1:0]        val_mem [NUM_FU][QDEPTH];
  logic [PTR_W-1:0]       head    [NUM_FU];
  logic [PTR_W-1:0]       tail    [NUM_FU];
  logic [CNT_W-1:0]       count   [NUM_FU];
  logic [SRC_W-1:0]       rr_ptr;
  logic [SRC_W-1:0]       gnt;
  logic                   grant;
  logic [NUM_FU-1:0]      nonempty;
  logic [NUM_FU-1:0]      push;
  logic [NUM_FU-1:0]      pop;
  logic [2*NUM_FU-1:0]    rot;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (32'(p) == 32'(QDEPTH - 1)) ? '0 : PTR_W'(32'(p) + 1);
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      nonempty[i] = (count[i] != '0);
      fu_stall[i] = (count[i] == CNT_W'(QDEPTH));
      push[i]     = fu_valid[i] && !fu_stall[i];
    end
    // Rotate the request vector so bit 0 is the current highest-priority unit.
    rot   = {nonempty, nonempty} >> rr_ptr;
    grant = 1'b0;
    gnt   = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (!grant && rot[i]) begin
        grant = 1'b1;
        gnt   = SRC_W'((32'(rr_ptr) + i) % NUM_FU);
      end
    end
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      pop[i] = grant && (gnt == SRC_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (push[i] && !flush) begin
        tag_mem[i][tail[i]] <= fu_tag[i*ROB_TAG_LEN +: ROB_TAG_LEN];
        val_mem[i][tail[i]] <= fu_value[i*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        head[i]  <= '0;
        tail[i]  <= '0;
        count[i] <= '0;
      end
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_value <= '0;
      cdb_src   <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        head[i]  <= '0;
        tail[i]  <= '0;
        count[i] <= '0;
      end
      cdb_valid <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        if (push[i]) tail[i] <= next_ptr(tail[i]);
        if (pop[i])  head[i] <= next_ptr(head[i]);
        if (push[i] && !pop[i])      count[i] <= count[i] + CNT_W'(1);
        else if (pop[i] && !push[i]) count[i] <= count[i] - CNT_W'(1);
      end
      if (grant) begin
        cdb_valid <= 1'b1;
        cdb_tag   <= tag_mem[gnt][head[gnt]];
        cdb_value <= val_mem[gnt][head[gnt]];
        cdb_src   <= gnt;
        rr_ptr    <= SRC_W'((32'(gnt) + 1) % NUM_FU);
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

endmodule
